// File: rtl/compare_pkg.sv
// Shared types for the compare arbiter: sequencer states and the flag bit positions of o_flags.
package compare_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    HOLD
  } state_e;

  localparam int NUM_FLAGS          = 6;
  localparam int FLAG_GREATER       = 0;
  localparam int FLAG_EQUAL         = 1;
  localparam int FLAG_LESS          = 2;
  localparam int FLAG_GREATER_EQUAL = 3;
  localparam int FLAG_NOT_EQUAL     = 4;
  localparam int FLAG_LESS_EQUAL    = 5;

endpackage

// File: rtl/Comparator.sv
// Unsigned magnitude comparator producing all six relational flags combinationally.
module Comparator #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_left,
  input  logic [N-1:0] i_right,
  output logic         o_greater,
  output logic         o_equal,
  output logic         o_less,
  output logic         o_greater_equal,
  output logic         o_not_equal,
  output logic         o_less_equal
);

  assign o_greater       = (i_left >  i_right);
  assign o_equal         = (i_left == i_right);
  assign o_less          = (i_left <  i_right);
  assign o_greater_equal = (i_left >= i_right);
  assign o_not_equal     = (i_left != i_right);
  assign o_less_equal    = (i_left <= i_right);

endmodule

// File: rtl/RoundRobinPicker.sv
// Combinational round-robin picker: first set request searching upward from pointer+1, wrapping mod R.
module RoundRobinPicker #(
  parameter  int R = 4,
  localparam int W = (R > 1) ? $clog2(R) : 1
) (
  input  logic [R-1:0] i_request,
  input  logic [W-1:0] i_pointer,
  output logic [R-1:0] o_onehot,
  output logic [W-1:0] o_index,
  output logic         o_any
);

  int idx;

  // Scan from farthest to nearest so the nearest hit after the pointer is the last one written.
  always_comb begin
    idx     = 0;
    o_index = '0;
    for (int i = R; i >= 1; i--) begin
      idx = (int'(i_pointer) + i) % R;
      if (i_request[idx]) begin
        o_index = W'(idx);
      end
    end
  end

  always_comb begin
    o_any    = |i_request;
    o_onehot = '0;
    for (int k = 0; k < R; k++) begin
      o_onehot[k] = o_any && (o_index == W'(k));
    end
  end

endmodule

// File: rtl/compare_arbiter.sv
// Round-robin arbiter sharing one Comparator among R requesters; results return via valid/ready
// tagged with the owning requester id.
module compare_arbiter
  import compare_pkg::*;
#(
  parameter  int N = 8,
  parameter  int R = 4,
  localparam int W = (R > 1) ? $clog2(R) : 1
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic [R-1:0]         i_request,
  input  logic [R*N-1:0]       i_left,
  input  logic [R*N-1:0]       i_right,
  output logic [R-1:0]         o_grant,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [W-1:0]         o_id,
  output logic [NUM_FLAGS-1:0] o_flags
);

  state_e               state_q;
  logic [W-1:0]         ptr_q;
  logic [N-1:0]         left_q;
  logic [N-1:0]         right_q;
  logic [W-1:0]         id_q;
  logic                 valid_q;
  logic [W-1:0]         oid_q;
  logic [NUM_FLAGS-1:0] flags_q;

  logic [R-1:0]         pick_onehot;
  logic [W-1:0]         pick_index;
  logic                 pick_any;
  logic                 grant_en;
  logic [N-1:0]         left_d;
  logic [N-1:0]         right_d;
  logic [NUM_FLAGS-1:0] flags_d;

  logic cmp_gt, cmp_eq, cmp_lt, cmp_ge, cmp_ne, cmp_le;

  RoundRobinPicker #(.R(R)) u_picker (
    .i_request (i_request),
    .i_pointer (ptr_q),
    .o_onehot  (pick_onehot),
    .o_index   (pick_index),
    .o_any     (pick_any)
  );

  Comparator #(.N(N)) u_cmp (
    .i_left          (left_q),
    .i_right         (right_q),
    .o_greater       (cmp_gt),
    .o_equal         (cmp_eq),
    .o_less          (cmp_lt),
    .o_greater_equal (cmp_ge),
    .o_not_equal     (cmp_ne),
    .o_less_equal    (cmp_le)
  );

  // Grant window: idle, or a held result is being accepted this very cycle.
  assign grant_en = i_reset_n && pick_any &&
                    ((state_q == IDLE) || ((state_q == HOLD) && i_ready));
  assign o_grant  = grant_en ? pick_onehot : '0;

  always_comb begin
    left_d  = '0;
    right_d = '0;
    for (int k = 0; k < R; k++) begin
      if (pick_onehot[k]) begin
        left_d  = i_left[k*N +: N];
        right_d = i_right[k*N +: N];
      end
    end
  end

  always_comb begin
    flags_d                     = '0;
    flags_d[FLAG_GREATER]       = cmp_gt;
    flags_d[FLAG_EQUAL]         = cmp_eq;
    flags_d[FLAG_LESS]          = cmp_lt;
    flags_d[FLAG_GREATER_EQUAL] = cmp_ge;
    flags_d[FLAG_NOT_EQUAL]     = cmp_ne;
    flags_d[FLAG_LESS_EQUAL]    = cmp_le;
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      ptr_q   <= W'(R - 1);
      left_q  <= '0;
      right_q <= '0;
      id_q    <= '0;
      valid_q <= 1'b0;
      oid_q   <= '0;
      flags_q <= '0;
    end else begin
      if (grant_en) begin
        left_q  <= left_d;
        right_q <= right_d;
        id_q    <= pick_index;
        ptr_q   <= pick_index;
      end
      case (state_q)
        IDLE: begin
          if (grant_en) state_q <= COMPARE;
        end
        COMPARE: begin
          flags_q <= flags_d;
          oid_q   <= id_q;
          valid_q <= 1'b1;
          state_q <= HOLD;
        end
        HOLD: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            state_q <= grant_en ? COMPARE : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_valid = valid_q;
  assign o_id    = oid_q;
  assign o_flags = flags_q;

endmodule

// File: tb/tb_compare_arbiter.sv
// Randomized and directed bench for compare_arbiter with a queue-based scoreboard and a
// request-level reference model of the arbitration and result protocol.
module tb_compare_arbiter;

  localparam int N = 8;
  localparam int R = 4;
  localparam int W = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [R-1:0]   i_request;
  logic [R*N-1:0] i_left;
  logic [R*N-1:0] i_right;
  logic [R-1:0]   o_grant;
  logic           o_valid;
  logic           i_ready;
  logic [W-1:0]   o_id;
  logic [5:0]     o_flags;

  compare_arbiter #(.N(N), .R(R)) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .i_request (i_request),
    .i_left    (i_left),
    .i_right   (i_right),
    .o_grant   (o_grant),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_id      (o_id),
    .o_flags   (o_flags)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int n_res = 0;

  // Model state: pending requests, last winner, and phase of the result in flight
  // (0 = nothing, 1 = being computed, 2 = presented on the output).
  logic [R-1:0]     req;
  logic             rdy;
  logic [N-1:0]     lft [R];
  logic [N-1:0]     rgt [R];
  int               ptr;
  int               ph;
  logic [W+5:0]     sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] ref_flags(input logic [N-1:0] l, input logic [N-1:0] r);
    return {l <= r, l != r, l >= r, l < r, l == r, l > r};
  endfunction

  function automatic int ref_winner(input logic [R-1:0] rq, input int p);
    for (int i = 1; i <= R; i++) begin
      if (rq[(p + i) % R]) return (p + i) % R;
    end
    return -1;
  endfunction

  task automatic drive();
    i_request = req;
    i_ready   = rdy;
    for (int k = 0; k < R; k++) begin
      i_left[k*N +: N]  = lft[k];
      i_right[k*N +: N] = rgt[k];
    end
  endtask

  task automatic step();
    logic         open;
    int           w;
    logic [R-1:0] exp_g;
    @(negedge clk);
    rst_n = 1'b1;
    drive();
    #1;
    chk("valid", 32'(o_valid), 32'(ph == 2));
    open  = (ph == 0) || ((ph == 2) && rdy);
    w     = ref_winner(req, ptr);
    exp_g = '0;
    if (open && w >= 0) exp_g[w] = 1'b1;
    chk("grant", 32'(o_grant), 32'(exp_g));
    @(posedge clk);
    if (ph == 1) begin
      ph = 2;
    end else if (open) begin
      if (w >= 0) begin
        sb.push_back({W'(w), ref_flags(lft[w], rgt[w])});
        ptr    = w;
        req[w] = 1'b0;
        ph     = 1;
      end else begin
        ph = 0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive();
    #1;
    chk("rst_grant", 32'(o_grant), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_flags", 32'(o_flags), 32'd0);
    chk("rst_id", 32'(o_id), 32'd0);
    ph  = 0;
    ptr = R - 1;
    sb.delete();
  endtask

  // Monitor: pops on every accepted result and checks hold stability under backpressure.
  initial begin
    logic         held;
    logic [5:0]   hf;
    logic [W-1:0] hid;
    logic [W+5:0] e;
    held = 1'b0;
    hf   = '0;
    hid  = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n !== 1'b1) begin
        held = 1'b0;
      end else begin
        if (held) begin
          chk("hold_valid", 32'(o_valid), 32'd1);
          chk("hold_flags", 32'(o_flags), 32'(hf));
          chk("hold_id", 32'(o_id), 32'(hid));
        end
        if (o_valid && i_ready) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_result: id %0d flags %b with empty scoreboard", o_id, o_flags);
          end else begin
            e = sb.pop_front();
            chk("res_id", 32'(o_id), 32'(e[W+5:6]));
            chk("res_flags", 32'(o_flags), 32'(e[5:0]));
            n_res++;
          end
        end
        held = o_valid && !i_ready;
        hf   = o_flags;
        hid  = o_id;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    i_request = '0;
    i_ready   = 1'b0;
    i_left    = '0;
    i_right   = '0;
    rdy       = 1'b1;
    req       = '1;
    ptr       = R - 1;
    ph        = 0;
    for (int k = 0; k < R; k++) begin
      lft[k] = 8'(k * 17);
      rgt[k] = 8'(k * 29);
    end

    // Reset with all requests high, then release: requester 0 first.
    do_reset();
    step();
    step();
    step();

    // Single compare on requester 2.
    do_reset();
    req = 4'b0100; lft[2] = 8'hA5; rgt[2] = 8'h5A;
    repeat (4) step();

    // Equality and less.
    req = 4'b0001; lft[0] = 8'h00; rgt[0] = 8'h00;
    repeat (3) step();
    req = 4'b0010; lft[1] = 8'h7F; rgt[1] = 8'h80;
    repeat (3) step();

    // Round-robin fairness with everyone requesting.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      req = '1;
      step();
    end
    req = '0;
    repeat (3) step();

    // Backpressure while requester 1 waits.
    req = 4'b0001; lft[0] = 8'h33; rgt[0] = 8'h44;
    step();
    step();
    rdy = 1'b0;
    req = 4'b0010; lft[1] = 8'hC0; rgt[1] = 8'hC0;
    repeat (5) step();
    rdy = 1'b1;
    repeat (4) step();

    // Reset during COMPARE, then during HOLD.
    req = 4'b0100;
    step();
    do_reset();
    req = '1;
    step();
    rdy = 1'b0;
    req = '0;
    step();
    step();
    do_reset();
    rdy = 1'b1;
    req = '1;
    step();
    req = '0;
    repeat (3) step();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      req = req | R'($urandom_range(0, (1 << R) - 1) & $urandom_range(0, (1 << R) - 1));
      rdy = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < R; k++) begin
        lft[k] = N'($urandom);
        rgt[k] = ($urandom_range(0, 3) == 0) ? lft[k] : N'($urandom);
      end
      step();
    end

    // Drain.
    req = '0;
    rdy = 1'b1;
    repeat (5) step();
    @(negedge clk);
    #3;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("results_seen", 32'(n_res > 50), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
